// File: rtl/pwr_xdomain_pkg.sv
// Shared types and helpers for the PD_LOW -> PD_HIGH power-domain crossing controller.
// Contents:
//   pwr_xdom_state_e : sequencer state encoding
//   cnt_w()          : counter width needed to hold values 0..max_val
package pwr_xdomain_pkg;

  typedef enum logic [3:0] {
    OFF     = 4'd0,
    SW_ON   = 4'd1,
    LS_ON   = 4'd2,
    ISO_REL = 4'd3,
    ON      = 4'd4,
    ISO_SET = 4'd5,
    LS_OFF  = 4'd6,
    SW_OFF  = 4'd7,
    ERR     = 4'd8
  } pwr_xdom_state_e;

  // Width of a saturating counter that must be able to reach max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pwr_iso_clamp_lane.sv
// One crossing lane: registered isolation clamp / level-shift stage.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   pass     : 1 = forward src, 0 = drive the clamp pattern
//   src      : lane data from PD_LOW
//   dst      : registered lane data into PD_HIGH
module pwr_iso_clamp_lane #(
  parameter int unsigned WIDTH    = 8,
  parameter logic        CLAMP_HI = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pass,
  input  logic [WIDTH-1:0] src,
  output logic [WIDTH-1:0] dst
);

  localparam logic [WIDTH-1:0] CLAMP_VAL = {WIDTH{CLAMP_HI}};

  // Output register: the only path from src to dst.
  always_ff @(posedge clk) begin
    if (rst) begin
      dst <= CLAMP_VAL;
    end else begin
      dst <= pass ? src : CLAMP_VAL;
    end
  end

endmodule

// File: rtl/pwr_xdomain_seq.sv
// Power-domain crossing controller for one switchable destination domain.
// Sequences power switch, level shifters and isolation; carries NUM_CH lanes
// through registered clamp stages.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   pd_req             : 1 = domain requested on
//   err_clr            : pulse, leaves ERR
//   sw_ack             : power-switch status (1 = rail up)
//   ch_mask            : per-lane enable (0 forces clamp)
//   src_data/dst_data  : NUM_CH x WIDTH lane data in / out
//   sw_en, ls_en, iso_en, pd_on, busy, err : registered control/status
module pwr_xdomain_seq
  import pwr_xdomain_pkg::*;
#(
  parameter int unsigned        NUM_CH      = 4,
  parameter int unsigned        WIDTH       = 8,
  parameter int unsigned        LS_SETTLE   = 4,
  parameter int unsigned        ACK_TIMEOUT = 16,
  parameter logic [NUM_CH-1:0]  CLAMP_HI    = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pd_req,
  input  logic                    err_clr,
  input  logic                    sw_ack,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic [NUM_CH*WIDTH-1:0] src_data,
  output logic                    sw_en,
  output logic                    ls_en,
  output logic                    iso_en,
  output logic [NUM_CH*WIDTH-1:0] dst_data,
  output logic                    pd_on,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned SET_W = cnt_w(LS_SETTLE);
  localparam int unsigned ACK_W = cnt_w(ACK_TIMEOUT);

  pwr_xdom_state_e  state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
  logic             sw_en_d, ls_en_d, iso_en_d, pd_on_d, busy_d, err_d;

  // State, counters and control outputs; outputs are decoded from the next state
  // so they track the state register without an extra cycle of lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= OFF;
      settle_q  <= '0;
      ack_cnt_q <= '0;
      sw_en     <= 1'b0;
      ls_en     <= 1'b0;
      iso_en    <= 1'b1;
      pd_on     <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      ack_cnt_q <= ack_cnt_d;
      sw_en     <= sw_en_d;
      ls_en     <= ls_en_d;
      iso_en    <= iso_en_d;
      pd_on     <= pd_on_d;
      busy      <= busy_d;
      err       <= err_d;
    end
  end

  // Next state, counters (zero outside their own state, so entry clears them) and output decode.
  always_comb begin
    state_d   = state_q;
    settle_d  = '0;
    ack_cnt_d = '0;
    sw_en_d   = 1'b0;
    ls_en_d   = 1'b0;
    iso_en_d  = 1'b1;
    pd_on_d   = 1'b0;
    busy_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      OFF:     if (pd_req) state_d = SW_ON;
      SW_ON: begin
        // A late ack on the final count still wins over the timeout.
        if (sw_ack) begin
          state_d = LS_ON;
        end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          ack_cnt_d = (ack_cnt_q == ACK_W'(ACK_TIMEOUT)) ? ack_cnt_q : ack_cnt_q + ACK_W'(1);
        end
      end
      LS_ON: begin
        if (settle_q == SET_W'(LS_SETTLE)) begin
          state_d = ISO_REL;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      ISO_REL: state_d = ON;
      ON:      if (!pd_req) state_d = ISO_SET;
      ISO_SET: state_d = LS_OFF;
      LS_OFF:  state_d = SW_OFF;
      SW_OFF: begin
        if (!sw_ack) begin
          state_d = OFF;
        end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          ack_cnt_d = (ack_cnt_q == ACK_W'(ACK_TIMEOUT)) ? ack_cnt_q : ack_cnt_q + ACK_W'(1);
        end
      end
      ERR:     if (err_clr) state_d = OFF;
      default: state_d = OFF;
    endcase

    unique case (state_d)
      SW_ON:   sw_en_d = 1'b1;
      LS_ON:   begin sw_en_d = 1'b1; ls_en_d = 1'b1; end
      ISO_REL: begin sw_en_d = 1'b1; ls_en_d = 1'b1; iso_en_d = 1'b0; end
      ON:      begin sw_en_d = 1'b1; ls_en_d = 1'b1; iso_en_d = 1'b0; pd_on_d = 1'b1; end
      ISO_SET: begin sw_en_d = 1'b1; ls_en_d = 1'b1; end
      LS_OFF:  sw_en_d = 1'b1;
      ERR:     err_d = 1'b1;
      default: ;
    endcase

    busy_d = !(state_d inside {OFF, ON, ERR});
  end

  // Lanes pass only while the registered isolation is released and the lane is enabled.
  logic [NUM_CH-1:0] lane_pass;
  assign lane_pass = ch_mask & {NUM_CH{~iso_en}};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    pwr_iso_clamp_lane #(
      .WIDTH    (WIDTH),
      .CLAMP_HI (CLAMP_HI[c])
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .pass (lane_pass[c]),
      .src  (src_data[c*WIDTH +: WIDTH]),
      .dst  (dst_data[c*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_pwr_xdomain_seq.sv
// Directed bench for pwr_xdomain_seq: power-up/down, mask, timeout, late ack, reset mid-sequence.
module tb_pwr_xdomain_seq;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned WIDTH  = 8;
  localparam logic [31:0] CLAMP  = 32'h0000_FF00;  // lane1 clamps high
  localparam logic [31:0] SRC    = 32'h443C_22A5;

  logic                    clk = 1'b0;
  logic                    rst, pd_req, err_clr, sw_ack;
  logic [NUM_CH-1:0]       ch_mask;
  logic [NUM_CH*WIDTH-1:0] src_data, dst_data;
  logic                    sw_en, ls_en, iso_en, pd_on, busy, err;

  int n_checks = 0;
  int n_pass   = 0;

  pwr_xdomain_seq #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .LS_SETTLE(4), .ACK_TIMEOUT(16), .CLAMP_HI(4'b0010)
  ) dut (
    .clk(clk), .rst(rst), .pd_req(pd_req), .err_clr(err_clr), .sw_ack(sw_ack),
    .ch_mask(ch_mask), .src_data(src_data), .sw_en(sw_en), .ls_en(ls_en),
    .iso_en(iso_en), .dst_data(dst_data), .pd_on(pd_on), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
  endtask

  // Advance n clock edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; pd_req = 1'b0; err_clr = 1'b0; sw_ack = 1'b0;
    ch_mask = 4'hF; src_data = SRC;
    step(2);
    check("rst_sw_en",  32'(sw_en),  32'd0);
    check("rst_ls_en",  32'(ls_en),  32'd0);
    check("rst_iso_en", 32'(iso_en), 32'd1);
    check("rst_pd_on",  32'(pd_on),  32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_err",    32'(err),    32'd0);
    check("rst_dst",    dst_data,    CLAMP);

    // Power-up: cycle 0 is the first edge in SW_ON.
    rst = 1'b0; pd_req = 1'b1;
    step(1);
    check("up_c0_sw_en", 32'(sw_en), 32'd1);
    check("up_c0_ls_en", 32'(ls_en), 32'd0);
    check("up_c0_busy",  32'(busy),  32'd1);
    step(2);
    check("up_c2_ls_en", 32'(ls_en), 32'd0);
    sw_ack = 1'b1;
    step(1);
    check("up_c3_ls_en",  32'(ls_en),  32'd1);
    check("up_c3_iso_en", 32'(iso_en), 32'd1);
    step(4);
    check("up_c7_iso_en", 32'(iso_en), 32'd1);
    step(1);
    check("up_c8_iso_en", 32'(iso_en), 32'd0);
    check("up_c8_pd_on",  32'(pd_on),  32'd0);
    check("up_c8_dst",    dst_data,    CLAMP);
    step(1);
    check("up_c9_pd_on", 32'(pd_on), 32'd1);
    check("up_c9_busy",  32'(busy),  32'd0);
    check("up_c9_dst",   dst_data,   SRC);

    // Lane mask in ON.
    ch_mask = 4'b1011;
    step(1);
    check("mask_dst", dst_data, 32'h4400_22A5);
    ch_mask = 4'hF;
    step(1);
    check("unmask_dst", dst_data, SRC);

    // Power-down from ON.
    pd_req = 1'b0;
    step(1);
    check("dn_iso_en", 32'(iso_en), 32'd1);
    check("dn_ls_en1", 32'(ls_en),  32'd1);
    check("dn_pd_on",  32'(pd_on),  32'd0);
    step(1);
    check("dn_ls_en0", 32'(ls_en), 32'd0);
    check("dn_sw_en1", 32'(sw_en), 32'd1);
    check("dn_dst",    dst_data,   CLAMP);
    step(1);
    check("dn_sw_en0", 32'(sw_en), 32'd0);
    check("dn_busy1",  32'(busy),  32'd1);
    sw_ack = 1'b0;
    step(1);
    check("dn_off_busy", 32'(busy), 32'd0);
    check("dn_off_dst",  dst_data,  CLAMP);

    // Ack timeout: ERR after exactly 16 cycles in SW_ON.
    pd_req = 1'b1;
    step(1);
    check("to_c0_sw_en", 32'(sw_en), 32'd1);
    step(15);
    check("to_c15_err", 32'(err), 32'd0);
    step(1);
    check("to_c16_err",    32'(err),    32'd1);
    check("to_c16_sw_en",  32'(sw_en),  32'd0);
    check("to_c16_iso_en", 32'(iso_en), 32'd1);
    check("to_c16_busy",   32'(busy),   32'd0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("clr_err",  32'(err),  32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    step(1);
    check("reentry_sw_en", 32'(sw_en), 32'd1);

    // Ack on the final timeout cycle wins.
    step(15);
    check("late_c15_err",  32'(err),   32'd0);
    check("late_c15_ls",   32'(ls_en), 32'd0);
    sw_ack = 1'b1;
    step(1);
    check("late_c16_ls",  32'(ls_en), 32'd1);
    check("late_c16_err", 32'(err),   32'd0);

    // Reset while in LS_ON.
    rst = 1'b1;
    step(1);
    check("mid_rst_sw_en",  32'(sw_en),  32'd0);
    check("mid_rst_ls_en",  32'(ls_en),  32'd0);
    check("mid_rst_iso_en", 32'(iso_en), 32'd1);
    check("mid_rst_busy",   32'(busy),   32'd0);
    check("mid_rst_dst",    dst_data,    CLAMP);
    rst = 1'b0; sw_ack = 1'b0; pd_req = 1'b0;
    step(1);

    // Two-cycle request pulse: full power-up, one ON cycle, then power-down.
    pd_req = 1'b1;
    step(1);
    check("pulse_c0_sw_en", 32'(sw_en), 32'd1);
    step(1);
    pd_req = 1'b0;
    step(1);
    sw_ack = 1'b1;
    step(6);
    check("pulse_c8_pd_on", 32'(pd_on), 32'd0);
    step(1);
    check("pulse_c9_pd_on", 32'(pd_on), 32'd1);
    step(1);
    check("pulse_c10_pd_on",  32'(pd_on),  32'd0);
    check("pulse_c10_iso_en", 32'(iso_en), 32'd1);
    step(1);
    check("pulse_c11_ls_en", 32'(ls_en), 32'd0);
    step(1);
    check("pulse_c12_sw_en", 32'(sw_en), 32'd0);
    sw_ack = 1'b0;
    step(1);
    check("pulse_off_busy", 32'(busy), 32'd0);
    check("pulse_off_dst",  dst_data,  CLAMP);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
